id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand selection for the 5-stage MIPS pipeline.
//  Captures decoded operands/control from ID; drives A, B, ALUC straight into the ALU.
//  Performs MEM->EX and WB->EX forwarding and carries the MEM/WB control bits downstream.
// PARAMETERS
//  DW    32  datapath width (fixed 32 in this pipeline; parameter for lint/tb only)
//  RW    5   register index width
// PORTS
//  CLK            in   1   clock, rising edge
//  RST            in   1   synchronous reset, active high
//  STALL          in   1   hold all ID/EX registers this edge
//  FLUSH          in   1   load a bubble this edge (priority over STALL)
//  ID_VALID       in   1   ID holds a real instruction
//  ID_RS_DATA     in   32  register-file rs read data
//  ID_RT_DATA     in   32  register-file rt read data
//  ID_IMM         in   32  immediate, already sign/zero extended by ID
//  ID_SHAMT       in   5   instr[10:6]
//  ID_RS,ID_RT    in   5   source register indices
//  ID_WREG        in   5   destination index (RegDst already resolved in ID)
//  ID_ALUC        in   4   ALU op code (pipeline ALU encoding)
//  ID_ALUSRC      in   1   1: B = immediate, 0: B = rt
//  ID_SHSRC       in   1   1: A = {27'b0,shamt} (sll/srl/sra), 0: A = rs
//  ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG  in 1 each  control for later stages
//  MEM_REGWRITE   in   1   EX/MEM writes a register
//  MEM_WREG       in   5   EX/MEM destination
//  MEM_RESULT     in   32  EX/MEM ALU result
//  WB_REGWRITE    in   1   MEM/WB writes a register
//  WB_WREG        in   5   MEM/WB destination
//  WB_RESULT      in   32  MEM/WB write-back value
//  EX_A, EX_B     out  32  ALU operands (combinational from regs + forwarding)
//  EX_ALUC        out  4   ALU op code (registered)
//  EX_STORE_DATA  out  32  forwarded rt for sw (never the immediate)
//  EX_WREG        out  5   registered destination
//  EX_VALID, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG  out 1 each  registered
//  LOAD_USE       out  1   load-use hazard request to ID/IF (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RST=1 at edge): all registers 0; EX_ALUC=4'b0000, EX_VALID=0, all control 0,
//    EX_A=EX_B=EX_STORE_DATA=0 (rs=rt=0 so no forwarding). RST beats FLUSH beats STALL.
//  - FLUSH: registers load a bubble: VALID, REGWRITE, MEMREAD, MEMWRITE, MEMTOREG=0,
//    WREG=0, ALUC=0; data regs don't-care but clear to 0.
//  - STALL (no FLUSH): every register holds; forwarding still re-evaluates each cycle.
//  - Otherwise capture all ID_* each edge; latency ID->EX_ALUC/control = 1 cycle.
//  - Forwarding per source s in {rs,rt}, combinational, priority MEM > WB > regfile:
//    MEM hit = MEM_REGWRITE & MEM_WREG==s & s!=0; WB hit likewise; index 0 never forwards.
//  - EX_A = SHSRC ? {27'b0,SHAMT} : fwd(rs). EX_B = ALUSRC ? IMM : fwd(rt).
//  - EX_STORE_DATA = fwd(rt) regardless of ALUSRC.
//  - Bubble (EX_VALID=0) still drives legal A/B/ALUC; downstream keys off control bits.
//  - Widths exact; no arithmetic in this block.
// CONFIGURATION
//  IDEX_LOADUSE_DET_EN defined: LOAD_USE = EX_VALID & EX_MEMREAD & EX_WREG!=0 & ID_VALID &
//    (EX_WREG==ID_RS | EX_WREG==ID_RT); caller must assert STALL on ID/IF and FLUSH here.
//  Not defined: LOAD_USE tied 0; an external hazard unit owns load-use detection.
// STRUCTURE
//  Shared package pipe_defs: ALUC code constants (ADD..NOR), FWD_REG/FWD_MEM/FWD_WB select
//    codes, bubble control constant.
//  Sub-module ex_fwd_mux (index, regfile data, MEM/WB ports -> 32-bit value), instanced x2.
// TESTING
//  1 RST=1 with random ID_* -> next cycle all outputs 0, EX_ALUC=0, LOAD_USE=0.
//  2 add $3,$1,$2 (rs=1 data 5, rt=2 data 7) -> EX_A=5, EX_B=7, EX_ALUC=0000 one edge later.
//  3 MEM_WREG=1 MEM_RESULT=0x10 and WB_WREG=1 WB_RESULT=0x20 -> EX_A=0x10; with
//    MEM_REGWRITE=0 -> 0x20; rs=0 with MEM_WREG=0 -> EX_A=ID data, not forwarded.
//  4 sll rt=2 shamt=4, ALUC=0100, SHSRC=1 -> EX_A=4, EX_B=fwd(rt); sw ALUSRC=1 imm=8 ->
//    EX_B=8, EX_STORE_DATA=fwd(rt).
//  5 STALL 3 cycles with new ID_* -> outputs hold; STALL+FLUSH together -> bubble,
//    EX_VALID=0, EX_REGWRITE=0, EX_MEMWRITE=0.
//  6 (EN) lw $4 in EX, ID add rs=4 -> LOAD_USE=1; rs=0 with EX_WREG=0 -> LOAD_USE=0;
//    (no EN) LOAD_USE=0 always.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared pipeline definitions: ALU op codes, forwarding select codes and the
// ID/EX control bundle with its bubble value.
package pipe_defs;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0001;
  localparam logic [3:0] ALUC_AND = 4'b0010;
  localparam logic [3:0] ALUC_OR  = 4'b0011;
  localparam logic [3:0] ALUC_SLL = 4'b0100;
  localparam logic [3:0] ALUC_SRL = 4'b0101;
  localparam logic [3:0] ALUC_SRA = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_XOR = 4'b1000;
  localparam logic [3:0] ALUC_NOR = 4'b1001;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       shsrc;
    logic [3:0] aluc;
    logic [4:0] wreg;
  } idex_ctrl_t;

  localparam idex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_fwd_mux.sv
// Operand forwarding for one EX source: MEM result beats WB result beats the
// register-file value; register 0 is never forwarded.
module ex_fwd_mux
  import pipe_defs::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_wreg,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_wreg,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] val
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && (mem_wreg == idx) && (idx != '0))
      sel = FWD_MEM;
    else if (wb_regwrite && (wb_wreg == idx) && (idx != '0))
      sel = FWD_WB;
  end

  always_comb begin
    val = rf_data;
    case (sel)
      FWD_MEM: val = mem_result;
      FWD_WB:  val = wb_result;
      default: val = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand selection and forwarding.
// Optional load-use detection is enabled by defining IDEX_LOADUSE_DET_EN.
module id_ex_stage
  import pipe_defs::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic          ID_VALID,
  input  logic [DW-1:0] ID_RS_DATA,
  input  logic [DW-1:0] ID_RT_DATA,
  input  logic [DW-1:0] ID_IMM,
  input  logic [4:0]    ID_SHAMT,
  input  logic [RW-1:0] ID_RS,
  input  logic [RW-1:0] ID_RT,
  input  logic [RW-1:0] ID_WREG,
  input  logic [3:0]    ID_ALUC,
  input  logic          ID_ALUSRC,
  input  logic          ID_SHSRC,
  input  logic          ID_REGWRITE,
  input  logic          ID_MEMREAD,
  input  logic          ID_MEMWRITE,
  input  logic          ID_MEMTOREG,
  input  logic          MEM_REGWRITE,
  input  logic [RW-1:0] MEM_WREG,
  input  logic [DW-1:0] MEM_RESULT,
  input  logic          WB_REGWRITE,
  input  logic [RW-1:0] WB_WREG,
  input  logic [DW-1:0] WB_RESULT,
  output logic [DW-1:0] EX_A,
  output logic [DW-1:0] EX_B,
  output logic [3:0]    EX_ALUC,
  output logic [DW-1:0] EX_STORE_DATA,
  output logic [RW-1:0] EX_WREG,
  output logic          EX_VALID,
  output logic          EX_REGWRITE,
  output logic          EX_MEMREAD,
  output logic          EX_MEMWRITE,
  output logic          EX_MEMTOREG,
  output logic          LOAD_USE
);

  idex_ctrl_t    ctrl_p1;
  logic [DW-1:0] rs_data_p1;
  logic [DW-1:0] rt_data_p1;
  logic [DW-1:0] imm_p1;
  logic [4:0]    shamt_p1;
  logic [RW-1:0] rs_p1;
  logic [RW-1:0] rt_p1;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // ID -> EX register boundary; a flush clears data too so bubbles drive zeros
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      ctrl_p1    <= CTRL_BUBBLE;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      shamt_p1   <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
    end else if (!STALL) begin
      ctrl_p1.valid    <= ID_VALID;
      ctrl_p1.regwrite <= ID_REGWRITE;
      ctrl_p1.memread  <= ID_MEMREAD;
      ctrl_p1.memwrite <= ID_MEMWRITE;
      ctrl_p1.memtoreg <= ID_MEMTOREG;
      ctrl_p1.alusrc   <= ID_ALUSRC;
      ctrl_p1.shsrc    <= ID_SHSRC;
      ctrl_p1.aluc     <= ID_ALUC;
      ctrl_p1.wreg     <= ID_WREG;
      rs_data_p1       <= ID_RS_DATA;
      rt_data_p1       <= ID_RT_DATA;
      imm_p1           <= ID_IMM;
      shamt_p1         <= ID_SHAMT;
      rs_p1            <= ID_RS;
      rt_p1            <= ID_RT;
    end
  end

  ex_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx          (rs_p1),
    .rf_data      (rs_data_p1),
    .mem_regwrite (MEM_REGWRITE),
    .mem_wreg     (MEM_WREG),
    .mem_result   (MEM_RESULT),
    .wb_regwrite  (WB_REGWRITE),
    .wb_wreg      (WB_WREG),
    .wb_result    (WB_RESULT),
    .val          (fwd_rs)
  );

  ex_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx          (rt_p1),
    .rf_data      (rt_data_p1),
    .mem_regwrite (MEM_REGWRITE),
    .mem_wreg     (MEM_WREG),
    .mem_result   (MEM_RESULT),
    .wb_regwrite  (WB_REGWRITE),
    .wb_wreg      (WB_WREG),
    .wb_result    (WB_RESULT),
    .val          (fwd_rt)
  );

  assign EX_A          = ctrl_p1.shsrc  ? {{(DW-5){1'b0}}, shamt_p1} : fwd_rs;
  assign EX_B          = ctrl_p1.alusrc ? imm_p1 : fwd_rt;
  assign EX_STORE_DATA = fwd_rt;
  assign EX_ALUC       = ctrl_p1.aluc;
  assign EX_WREG       = ctrl_p1.wreg;
  assign EX_VALID      = ctrl_p1.valid;
  assign EX_REGWRITE   = ctrl_p1.regwrite;
  assign EX_MEMREAD    = ctrl_p1.memread;
  assign EX_MEMWRITE   = ctrl_p1.memwrite;
  assign EX_MEMTOREG   = ctrl_p1.memtoreg;

`ifdef IDEX_LOADUSE_DET_EN
  assign LOAD_USE = ctrl_p1.valid && ctrl_p1.memread && (ctrl_p1.wreg != '0) && ID_VALID &&
                    ((ctrl_p1.wreg == ID_RS) || (ctrl_p1.wreg == ID_RT));
`else
  // Load-use detection lives in the external hazard unit in this build
  logic unused_id_valid;
  assign unused_id_valid = ID_VALID;
  assign LOAD_USE = 1'b0;
`endif

endmodule
